// File: rtl/soc_bus_pkg.sv
// Shared types and helpers for the single-master SoC bus interconnect.
package soc_bus_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } bus_state_t;

    localparam logic [31:0] ERR_DATA_DEFAULT = 32'hDEAD_BEEF;

    // Timeout counter width; a disabled timeout still keeps a 1-bit counter.
    function automatic int unsigned cnt_width(input int unsigned timeout);
        return (timeout == 0) ? 1 : int'($clog2(timeout + 1));
    endfunction

    // Slave-select width; a single slave still gets a 1-bit select.
    function automatic int unsigned sel_width(input int unsigned nslv);
        return (nslv > 1) ? int'($clog2(nslv)) : 1;
    endfunction

endpackage

// File: rtl/soc_bus_decode.sv
// Priority address decoder: lowest-index matching window wins.
module soc_bus_decode
    import soc_bus_pkg::*;
#(
    parameter int unsigned          NSLV     = 2,
    parameter int unsigned          AW       = 32,
    parameter logic [NSLV*AW-1:0]   SLV_BASE = {32'h0000_1000, 32'h0000_0000},
    parameter logic [NSLV*AW-1:0]   SLV_MASK = {32'hFFFF_F000, 32'hFFFF_F000}
) (
    input  logic [AW-1:0]                 addr,
    output logic                          hit,
    output logic [sel_width(NSLV)-1:0]    sel
);

    localparam int unsigned SW = sel_width(NSLV);

    // Scan windows upward; the first hit locks out later (higher) indices.
    always_comb begin
        hit = 1'b0;
        sel = '0;
        for (int unsigned i = 0; i < NSLV; i++) begin
            if (!hit && ((addr & SLV_MASK[i*AW +: AW]) == SLV_BASE[i*AW +: AW])) begin
                hit = 1'b1;
                sel = SW'(i);
            end
        end
    end

endmodule

// File: rtl/soc_bus_xbar.sv
// Single-master to NSLV-slave bus interconnect with address windows,
// unmapped-address error, slave-hang timeout and a one-cycle done pulse.
module soc_bus_xbar
    import soc_bus_pkg::*;
#(
    parameter int unsigned          NSLV     = 2,
    parameter int unsigned          AW       = 32,
    parameter int unsigned          DW       = 32,
    parameter logic [NSLV*AW-1:0]   SLV_BASE = {32'h0000_1000, 32'h0000_0000},
    parameter logic [NSLV*AW-1:0]   SLV_MASK = {32'hFFFF_F000, 32'hFFFF_F000},
    parameter int unsigned          TIMEOUT  = 255,
    parameter logic [DW-1:0]        ERR_DATA = DW'(ERR_DATA_DEFAULT)
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic [AW-1:0]        m_addr,
    input  logic                 m_rw,
    input  logic [DW-1:0]        m_dwrite,
    input  logic                 m_valid,
    output logic [DW-1:0]        m_dread,
    output logic                 m_done,
    output logic                 m_err,
    output logic                 busy,
    output logic [AW-1:0]        s_addr,
    output logic                 s_rw,
    output logic [DW-1:0]        s_dwrite,
    output logic [NSLV-1:0]      s_valid,
    input  logic [NSLV*DW-1:0]   s_dread,
    input  logic [NSLV-1:0]      s_done
);

    localparam int unsigned     SW      = sel_width(NSLV);
    localparam int unsigned     CW      = cnt_width(TIMEOUT);
    localparam bit              TO_EN   = (TIMEOUT != 0);
    localparam logic [CW-1:0]   TO_LAST = CW'((TIMEOUT == 0) ? 0 : TIMEOUT - 1);

    bus_state_t      state, state_next;
    logic            dec_hit;
    logic [SW-1:0]   dec_sel;
    logic            hit_q;
    logic [SW-1:0]   sel_q;
    logic            err_q;
    logic [DW-1:0]   data_q;
    logic [CW-1:0]   cnt;
    logic            sel_done;
    logic [DW-1:0]   sel_rdata;
    logic            timeout_hit;

    soc_bus_decode #(
        .NSLV     (NSLV),
        .AW       (AW),
        .SLV_BASE (SLV_BASE),
        .SLV_MASK (SLV_MASK)
    ) u_decode (
        .addr (m_addr),
        .hit  (dec_hit),
        .sel  (dec_sel)
    );

    // Selected slave's response and the timeout condition.
    always_comb begin
        sel_done    = s_done[sel_q];
        sel_rdata   = s_dread[int'(sel_q)*DW +: DW];
        timeout_hit = TO_EN && (cnt == TO_LAST);
    end

    // State register.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic; completion wins over timeout in the same cycle.
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (m_valid) state_next = ISSUE;
            ISSUE:   state_next = hit_q ? WAIT : RESP;
            WAIT:    if (sel_done || timeout_hit) state_next = RESP;
            RESP:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Request latch, timeout counter and response capture.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            s_addr   <= '0;
            s_rw     <= 1'b0;
            s_dwrite <= '0;
            hit_q    <= 1'b0;
            sel_q    <= '0;
            err_q    <= 1'b0;
            data_q   <= '0;
            cnt      <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (m_valid) begin
                        s_addr   <= m_addr;
                        s_rw     <= m_rw;
                        s_dwrite <= m_dwrite;
                        hit_q    <= dec_hit;
                        sel_q    <= dec_sel;
                    end
                end
                ISSUE: begin
                    cnt <= '0;
                    if (!hit_q) begin
                        err_q  <= 1'b1;
                        data_q <= s_rw ? '0 : ERR_DATA;
                    end
                end
                WAIT: begin
                    if (sel_done) begin
                        err_q  <= 1'b0;
                        data_q <= s_rw ? '0 : sel_rdata;
                    end else if (timeout_hit) begin
                        err_q  <= 1'b1;
                        data_q <= s_rw ? '0 : ERR_DATA;
                    end else if (cnt != '1) begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    // Outputs decoded from state; m_dread simply holds the last response.
    always_comb begin
        busy    = (state != IDLE);
        m_done  = (state == RESP);
        m_err   = (state == RESP) && err_q;
        m_dread = data_q;
        s_valid = '0;
        if (state == ISSUE && hit_q) s_valid[sel_q] = 1'b1;
    end

endmodule
